bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Arbitrates the shared memory-mapped bus (16-bit address, active-low nRead/nWrite, 256-bit data) between NUM_REQ requesters, e.g. Execution and a matrix-load DMA.
- Runs one fixed-length bus transaction at a time and returns read data plus a one-cycle ack to the winning requester.
- Sits between the requesters and the shared MainMemory, MatrixAlu and IntegerAlu bus.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ACCESS_CYCLES, 2: cycles the strobe stays low per transaction (>=1).
- DATA_W, 256: data bus width.
- ADDR_W, 16: address width.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- nReset  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held until ack.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester address; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data.
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction.
- ack  out  NUM_REQ  one-cycle completion pulse to the winner.
- rdata  out  DATA_W  read data, valid in the ack cycle and held until the next read completes.
- address  out  ADDR_W  shared bus address.
- nRead  out  1  active-low read strobe.
- nWrite  out  1  active-low write strobe.
- bus_wdata  out  DATA_W  write data driven onto the shared bus.
- bus_rdata  in  DATA_W  OR of the slave data outputs.

Behaviour:
- Reset (nReset=0 at an edge): state=IDLE; gnt=0; ack=0; address=0; nRead=1; nWrite=1; bus_wdata=0; rdata=0; rr_ptr=0.
- A reset mid-transaction aborts it. No ack is issued and the bus is released at that edge.
- States: IDLE, STROBE, RESP.
- IDLE:
  - If req != 0, select the winner round-robin: the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch the winner's addr, we and wdata. Next state is STROBE.
  - If req == 0, stay in IDLE.
- STROBE (lasts exactly ACCESS_CYCLES cycles, counted by cnt, 0..ACCESS_CYCLES-1):
  - gnt[winner]=1; address=latched addr.
  - Read: nRead=0, nWrite=1. Write: nWrite=0, nRead=1, bus_wdata=latched data.
  - At the edge ending the last STROBE cycle, a read captures bus_rdata into rdata. Next state is RESP.
- RESP (one cycle):
  - ack[winner]=1; gnt=0; nRead=nWrite=1; address holds its value.
  - rr_ptr=(winner+1) mod NUM_REQ. Next state is IDLE.
- Latency: req sampled in IDLE at edge E gives gnt/strobe in cycles E+1..E+ACCESS_CYCLES and ack in cycle E+ACCESS_CYCLES+1. The earliest next grant is at E+ACCESS_CYCLES+3, so there is always one idle bus cycle between transactions (turnaround).
- A requester that deasserts req after grant does not abort the transaction; it completes and acks normally.
- A req withdrawn before grant is simply not selected.
- Inputs other than req are sampled only in IDLE. Changes during STROBE are ignored.
- nRead and nWrite are never low simultaneously. gnt is never multi-hot. ack is never multi-hot.
- A write does not modify rdata.
- Simultaneous requests are resolved by rr_ptr only; no starvation. Each requester waits at most NUM_REQ-1 transactions.

Optional Feature:
- Macro BUS_ARB_FIXED_PRIO_EN.
- Defined: requester 0 has strict priority; the remaining requesters are round-robin among themselves when req[0]=0, and rr_ptr never selects index 0.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset: hold nReset=0 for 2 cycles with req=2'b11. Required: gnt=0, ack=0, nRead=nWrite=1, address=0 throughout.
- Single read, ACCESS_CYCLES=2: req[0]=1, we=0, addr=16'h0006, bus_rdata=256'h47fff6fff6fff7. Required: nRead low exactly 2 cycles with address=6; ack[0] one cycle later; rdata=256'h47fff6fff6fff7.
- Single write: req[1]=1, we=1, addr=16'h0003, wdata=256'hAB. Required: nWrite low 2 cycles, bus_wdata=256'hAB, nRead stays high, ack[1] pulses, rdata unchanged.
- Contention: req=2'b11 held continuously from reset. Required: grants alternate 0,1,0,1 with one idle cycle between transactions; each ack goes to the current gnt index.
- Reset mid-transaction: assert nReset=0 during the 2nd STROBE cycle. Required: next cycle strobes are high, gnt=0, no ack; after release, a pending req[0] restarts from IDLE.
- With BUS_ARB_FIXED_PRIO_EN defined: req=2'b11 held continuously. Required: requester 0 wins every arbitration and requester 1 is granted only once req[0] is dropped.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter running one fixed-length transaction at a time on the shared memory bus.
// Define BUS_ARB_FIXED_PRIO_EN to give requester 0 strict priority over the round-robin pool.
module bus_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ACCESS_CYCLES = 2,
    parameter int DATA_W        = 256,
    parameter int ADDR_W        = 16
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         address,
    output logic                      nRead,
    output logic                      nWrite,
    output logic [DATA_W-1:0]         bus_wdata,
    input  logic [DATA_W-1:0]         bus_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STROBE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  winner;
    logic              latchedWe;

    logic              found;
    logic [PTR_W-1:0]  pick;
    logic [PTR_W:0]    scanIdx;
    logic [PTR_W-1:0]  nextPtr;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;
    logic              selWe;

    // Scan upward from rrPtr with wrap; in priority mode index 0 preempts and is kept out of the scan.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        scanIdx = '0;
        if (FixedPrio && req[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scanIdx = {1'b0, rrPtr} + (PTR_W+1)'(k);
                if (scanIdx >= (PTR_W+1)'(NUM_REQ))
                    scanIdx = scanIdx - (PTR_W+1)'(NUM_REQ);
                if (!found && !(FixedPrio && scanIdx == '0) && req[scanIdx[PTR_W-1:0]]) begin
                    found = 1'b1;
                    pick  = scanIdx[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        selAddr = '0;
        selData = '0;
        selWe   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == PTR_W'(i)) begin
                selAddr = req_addr[i*ADDR_W +: ADDR_W];
                selData = req_wdata[i*DATA_W +: DATA_W];
                selWe   = req_we[i];
            end
        end
    end

    // A priority-mode win by requester 0 leaves the pool pointer where it was.
    always_comb begin
        if (FixedPrio && winner == '0)
            nextPtr = rrPtr;
        else if (winner == PTR_W'(NUM_REQ-1))
            nextPtr = FixedPrio ? PTR_W'(1) : '0;
        else
            nextPtr = winner + PTR_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state     <= IDLE;
            cnt       <= '0;
            rrPtr     <= '0;
            winner    <= '0;
            latchedWe <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            address   <= '0;
            nRead     <= 1'b1;
            nWrite    <= 1'b1;
            bus_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        winner    <= pick;
                        latchedWe <= selWe;
                        address   <= selAddr;
                        gnt       <= NUM_REQ'(1) << pick;
                        nRead     <= selWe;
                        nWrite    <= !selWe;
                        bus_wdata <= selWe ? selData : '0;
                        cnt       <= '0;
                        state     <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt == CNT_W'(ACCESS_CYCLES-1)) begin
                        gnt    <= '0;
                        ack    <= gnt;
                        nRead  <= 1'b1;
                        nWrite <= 1'b1;
                        if (!latchedWe)
                            rdata <= bus_rdata;
                        rrPtr  <= nextPtr;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
